timer_apb_if: RTL

TIMER_APB_IF -- requirements
Module: timer_apb_if

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_apb_if.sv | 131 +++++++++++++
 2 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: register map and APB-interface FSM state encoding.
package timer_pkg;

  localparam logic [7:0] AddrTdr = 8'h00;
  localparam logic [7:0] AddrTcr = 8'h01;
  localparam logic [7:0] AddrTsr = 8'h02;
  localparam logic [7:0] AddrMax = AddrTsr;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/timer_apb_if.sv
// APB slave front-end for the timer register bank: latches each transfer,
// inserts WAIT_CYCLES wait states and strobes the bank once per transfer.
module timer_apb_if
  import timer_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  ADDR_MAX    = AddrMax
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata
);

  localparam logic [2:0] WaitLoad = 3'(WAIT_CYCLES);
  localparam bit         NoWait   = (WAIT_CYCLES == 0);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rbuf_q, rbuf_d;
  logic [7:0] prdata_q, prdata_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic       wr_en_q, wr_en_d;
  logic       setup, mapped_d, rd_fire;

  assign setup = (state_q == StIdle) && psel && !penable;

  // Without wait states there is no WAIT cycle to read in, so the bank is read
  // during SETUP with the incoming address forwarded straight to reg_addr.
  assign rd_fire = NoWait ? (setup && !pwrite && (paddr <= ADDR_MAX))
                          : ((state_q == StWait) && (cnt_q == WaitLoad) && psel && penable &&
                             !write_q && (addr_q <= ADDR_MAX));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rd_fire ? reg_rdata : rbuf_q;
    prdata_d  = 8'h00;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wr_en_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (setup) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          write_d = pwrite;
          cnt_d   = WaitLoad;
          state_d = NoWait ? StDone : StWait;
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else if (penable) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
      default: state_d = StIdle;
    endcase

    // Completion outputs are registered so they line up with the DONE cycle.
    mapped_d = (addr_d <= ADDR_MAX);
    if ((state_d == StDone) && (state_q != StDone)) begin
      pready_d  = 1'b1;
      pslverr_d = !mapped_d;
      wr_en_d   = write_d && mapped_d;
      if (!write_d && mapped_d) prdata_d = rbuf_d;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      write_q   <= 1'b0;
      addr_q    <= AddrTdr;
      wdata_q   <= 8'h00;
      rbuf_q    <= 8'h00;
      prdata_q  <= 8'h00;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_fire;
  assign reg_addr  = (NoWait && setup) ? paddr : addr_q;
  assign reg_wdata = wdata_q;

endmodule
